// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a tri-state bus driver and a flag register.
// Seven single-cycle operations complete at the edge that samples start.
// Optional macro ALU_MUL_EN adds a shift-add unsigned multiplier (op 7) with
// a start/busy/done handshake. Without the macro, op 7 completes in one cycle
// with result 0.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             fi,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             oe,
   output logic             busy,
   output logic             done,
   output logic             zf,
   output logic             cf,
   output logic             nf,
   inout  wire  [WIDTH-1:0] bus
);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;

   logic [WIDTH-1:0] result_reg;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cf;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;

   // The bus carries the held result whenever oe is high, in any state.
   assign bus = oe ? result_reg : {WIDTH{1'bz}};

   // The extra top bit of sum is the carry out; for diff it is the borrow.
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   // Single-cycle operation result and carry; op 7 yields 0 here.
   always_comb begin
      alu_res = '0;
      alu_cf  = 1'b0;
      case (op)
         OP_ADD: begin alu_res = sum[WIDTH-1:0];  alu_cf = sum[WIDTH];  end
         OP_SUB: begin alu_res = diff[WIDTH-1:0]; alu_cf = diff[WIDTH]; end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_SHL: begin alu_res = {a[WIDTH-2:0], 1'b0}; alu_cf = a[WIDTH-1]; end
         OP_SHR: begin alu_res = {1'b0, a[WIDTH-1:1]}; alu_cf = a[0];       end
         default: begin alu_res = '0; alu_cf = 1'b0; end
      endcase
   end

`ifdef ALU_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, MUL} state_t;

   state_t             state_reg;
   logic [2*WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0]   mplr_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [2*WIDTH-1:0] acc_next;
   logic [CW-1:0]      cnt_reg;
   logic               fi_reg;

   // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
   assign acc_next = acc_reg + (mplr_reg[0] ? mcand_reg : '0);

   // Control FSM: single-cycle ops complete in IDLE, multiply iterates in MUL.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         result_reg <= '0;
         zf         <= 1'b0;
         cf         <= 1'b0;
         nf         <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mcand_reg  <= '0;
         mplr_reg   <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         fi_reg     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (op == 3'd7) begin
                     mcand_reg <= {{WIDTH{1'b0}}, a};
                     mplr_reg  <= b;
                     acc_reg   <= '0;
                     cnt_reg   <= CW'(WIDTH);
                     fi_reg    <= fi;
                     busy      <= 1'b1;
                     state_reg <= MUL;
                  end else begin
                     result_reg <= alu_res;
                     done       <= 1'b1;
                     if (fi) begin
                        zf <= (alu_res == '0);
                        cf <= alu_cf;
                        nf <= alu_res[WIDTH-1];
                     end
                  end
               end
            end
            MUL: begin
               acc_reg   <= acc_next;
               mcand_reg <= mcand_reg << 1;
               mplr_reg  <= mplr_reg >> 1;
               cnt_reg   <= cnt_reg - CW'(1);
               // Last iteration: the product is complete in acc_next.
               if (cnt_reg == CW'(1)) begin
                  result_reg <= acc_next[WIDTH-1:0];
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  state_reg  <= IDLE;
                  if (fi_reg) begin
                     zf <= (acc_next[WIDTH-1:0] == '0);
                     cf <= |acc_next[2*WIDTH-1:WIDTH];
                     nf <= acc_next[WIDTH-1];
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
`else
   assign busy = 1'b0;

   // Every operation, including op 7, completes at the edge that samples start.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_reg <= '0;
         zf         <= 1'b0;
         cf         <= 1'b0;
         nf         <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            result_reg <= alu_res;
            done       <= 1'b1;
            if (fi) begin
               zf <= (alu_res == '0);
               cf <= alu_cf;
               nf <= alu_res[WIDTH-1];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=8), directed and random
// stimulus against an arithmetic reference model. Honours ALU_MUL_EN.
module tb_alu_seq;

   localparam int W = 8;
   localparam longint unsigned M = 64'd1 << W;

   logic          clk = 1'b0;
   logic          rst, start, fi, oe;
   logic [2:0]    op;
   logic [W-1:0]  a, b;
   logic          busy, done, zf, cf, nf;
   wire  [W-1:0]  bus;
   logic          ext_en;
   logic [W-1:0]  ext_val;
   logic [W+4:0]  obs;

   int checks = 0;
   int errors = 0;

   logic [W-1:0]  m_res;
   logic          m_zf, m_cf, m_nf;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .fi(fi),
      .a(a), .b(b), .oe(oe), .busy(busy), .done(done),
      .zf(zf), .cf(cf), .nf(nf), .bus(bus)
   );

   assign bus = ext_en ? ext_val : {W{1'bz}};
   assign obs = {done, busy, zf, cf, nf, bus};

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   // Reference: returns {carry, result} from plain integer arithmetic.
   function automatic logic [W:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      longint unsigned ux, uy, r;
      logic c;
      ux = x; uy = y; r = 0; c = 1'b0;
      case (o)
         3'd0: begin r = ux + uy;     c = (r >= M);   end
         3'd1: begin r = ux + M - uy; c = (ux < uy);  end
         3'd2: r = ux & uy;
         3'd3: r = ux | uy;
         3'd4: r = ux ^ uy;
         3'd5: begin r = ux * 2;      c = (ux >= M/2); end
         3'd6: begin r = ux / 2;      c = (ux % 2 == 1); end
         default: begin
`ifdef ALU_MUL_EN
            r = ux * uy; c = (r >= M);
`else
            r = 0; c = 1'b0;
`endif
         end
      endcase
      return {c, W'(r % M)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one start for one edge, then scramble inputs (they must not matter).
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic f);
      start = 1'b1; op = o; a = x; b = y; fi = f;
      tick();
      start = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom); fi = 1'($urandom);
   endtask

   task automatic commit(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic f);
      logic [W:0] cr;
      cr = ref_op(o, x, y);
      m_res = cr[W-1:0];
      if (f) begin
         m_zf = (cr[W-1:0] == '0);
         m_cf = cr[W];
         m_nf = cr[W-1];
      end
      $display("op=%0d a=%02h b=%02h fi=%0b -> result=%02h zf=%0b cf=%0b nf=%0b", o, x, y, f, m_res, m_zf, m_cf, m_nf);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_res = '0; m_zf = 1'b0; m_cf = 1'b0; m_nf = 1'b0;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset: got %h required %h", obs, {(W+5){1'b0}});
      end
   endtask

   task automatic test_directed();
      issue(3'd0, 8'd200, 8'd100, 1'b1); commit(3'd0, 8'd200, 8'd100, 1'b1);
      checks++;
      if (obs !== {5'b10010, 8'h2C}) begin errors++; $display("FAIL add_200_100: got %h required %h", obs, {5'b10010, 8'h2C}); end
      issue(3'd1, 8'd3, 8'd5, 1'b1); commit(3'd1, 8'd3, 8'd5, 1'b1);
      checks++;
      if (obs !== {5'b10011, 8'hFE}) begin errors++; $display("FAIL sub_3_5: got %h required %h", obs, {5'b10011, 8'hFE}); end
      issue(3'd1, 8'd5, 8'd5, 1'b1); commit(3'd1, 8'd5, 8'd5, 1'b1);
      checks++;
      if (obs !== {5'b10100, 8'h00}) begin errors++; $display("FAIL sub_5_5: got %h required %h", obs, {5'b10100, 8'h00}); end
      issue(3'd5, 8'h81, 8'h00, 1'b0); commit(3'd5, 8'h81, 8'h00, 1'b0);
      checks++;
      if (obs !== {5'b10100, 8'h02}) begin errors++; $display("FAIL shl_fi0: got %h required %h", obs, {5'b10100, 8'h02}); end
      issue(3'd6, 8'h03, 8'h00, 1'b1); commit(3'd6, 8'h03, 8'h00, 1'b1);
      checks++;
      if (obs !== {5'b10010, 8'h01}) begin errors++; $display("FAIL shr_3: got %h required %h", obs, {5'b10010, 8'h01}); end
      tick();
      checks++;
      if (obs !== {5'b00010, 8'h01}) begin errors++; $display("FAIL done_pulse: got %h required %h", obs, {5'b00010, 8'h01}); end
   endtask

`ifdef ALU_MUL_EN
   task automatic test_mul();
      issue(3'd7, 8'd15, 8'd17, 1'b1);
      for (int i = 0; i < W; i++) begin
         checks++;
         if (obs !== {2'b01, m_zf, m_cf, m_nf, m_res}) begin
            errors++; $display("FAIL mul_busy_cycle%0d: got %h required %h", i, obs, {2'b01, m_zf, m_cf, m_nf, m_res});
         end
         if (i == 3) begin start = 1'b1; op = 3'd0; a = 8'd1; b = 8'd1; fi = 1'b1; end
         else begin start = 1'b0; a = W'($urandom); b = W'($urandom); op = 3'($urandom); end
         tick();
      end
      start = 1'b0;
      commit(3'd7, 8'd15, 8'd17, 1'b1);
      checks++;
      if (obs !== {5'b10001, 8'hFF}) begin errors++; $display("FAIL mul_15_17: got %h required %h", obs, {5'b10001, 8'hFF}); end
      tick();
      checks++;
      if (obs !== {5'b00001, 8'hFF}) begin errors++; $display("FAIL mul_ignored_start: got %h required %h", obs, {5'b00001, 8'hFF}); end
      issue(3'd7, 8'd16, 8'd16, 1'b1);
      repeat (W) tick();
      commit(3'd7, 8'd16, 8'd16, 1'b1);
      checks++;
      if (obs !== {5'b10110, 8'h00}) begin errors++; $display("FAIL mul_16_16: got %h required %h", obs, {5'b10110, 8'h00}); end
   endtask
`else
   task automatic test_mul();
      issue(3'd7, 8'd15, 8'd17, 1'b1); commit(3'd7, 8'd15, 8'd17, 1'b1);
      checks++;
      if (obs !== {5'b10100, 8'h00}) begin errors++; $display("FAIL mul_disabled: got %h required %h", obs, {5'b10100, 8'h00}); end
   endtask
`endif

   task automatic test_bus();
      issue(3'd4, 8'hA5, 8'h0F, 1'b0); commit(3'd4, 8'hA5, 8'h0F, 1'b0);
      oe = 1'b0; ext_en = 1'b1; ext_val = 8'h5A;
      #1;
      checks++;
      if (bus !== 8'h5A) begin errors++; $display("FAIL bus_released: got %h required %h", bus, 8'h5A); end
      ext_en = 1'b0; oe = 1'b1;
      #1;
      checks++;
      if (bus !== 8'hAA) begin errors++; $display("FAIL bus_driven: got %h required %h", bus, 8'hAA); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] o;
      logic [W-1:0] x, y;
      logic f;
      for (int i = 0; i < 20; i++) begin
         o = 3'($urandom_range(0, 6)); x = W'($urandom); y = W'($urandom); f = 1'($urandom);
         start = 1'b1; op = o; a = x; b = y; fi = f;
         tick();
         commit(o, x, y, f);
         checks++;
         if (obs !== {2'b10, m_zf, m_cf, m_nf, m_res}) begin
            errors++; $display("FAIL back_to_back%0d: got %h required %h", i, obs, {2'b10, m_zf, m_cf, m_nf, m_res});
         end
      end
      start = 1'b0;
   endtask

   task automatic test_random();
      logic [2:0] o;
      logic [W-1:0] x, y;
      logic f;
      for (int i = 0; i < 30; i++) begin
         o = 3'($urandom); x = W'($urandom); y = W'($urandom); f = 1'($urandom);
         issue(o, x, y, f);
`ifdef ALU_MUL_EN
         if (o == 3'd7) begin
            for (int k = 0; k < W; k++) begin
               checks++;
               if (obs !== {2'b01, m_zf, m_cf, m_nf, m_res}) begin
                  errors++; $display("FAIL random%0d_busy%0d: got %h required %h", i, k, obs, {2'b01, m_zf, m_cf, m_nf, m_res});
               end
               tick();
            end
         end
`endif
         commit(o, x, y, f);
         checks++;
         if (obs !== {2'b10, m_zf, m_cf, m_nf, m_res}) begin
            errors++; $display("FAIL random%0d: got %h required %h", i, obs, {2'b10, m_zf, m_cf, m_nf, m_res});
         end
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   task automatic test_reset_mid_op();
      issue(3'd0, 8'h80, 8'h01, 1'b1); commit(3'd0, 8'h80, 8'h01, 1'b1);
`ifdef ALU_MUL_EN
      issue(3'd7, 8'h0F, 8'h03, 1'b1);
      repeat (3) tick();
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_res = '0; m_zf = 1'b0; m_cf = 1'b0; m_nf = 1'b0;
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_mid_op: got %h required %h", obs, {(W+5){1'b0}}); end
      tick();
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_stays_idle: got %h required %h", obs, {(W+5){1'b0}}); end
      issue(3'd0, 8'd1, 8'd1, 1'b1); commit(3'd0, 8'd1, 8'd1, 1'b1);
      checks++;
      if (obs !== {5'b10000, 8'h02}) begin errors++; $display("FAIL add_after_reset: got %h required %h", obs, {5'b10000, 8'h02}); end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; fi = 1'b0;
      oe = 1'b1; ext_en = 1'b0; ext_val = '0;
      m_res = '0; m_zf = 1'b0; m_cf = 1'b0; m_nf = 1'b0;
      tick();
      test_reset();
      test_directed();
      test_mul();
      test_bus();
      test_back_to_back();
      test_random();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
